// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - AES-128 key-expansion controller with round-key table (optional stream: KEY_SCHED_STREAM_EN)

module aes_expand_key (
    input  logic [127:0] key,
    input  logic [7:0]   count,
    output logic [127:0] exkey
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    logic [7:0]  rcon;
    logic [31:0] rot_w, temp_w, w0, w1, w2, w3;

    always_comb begin
        case (count)
            8'd1:    rcon = 8'h01;
            8'd2:    rcon = 8'h02;
            8'd3:    rcon = 8'h04;
            8'd4:    rcon = 8'h08;
            8'd5:    rcon = 8'h10;
            8'd6:    rcon = 8'h20;
            8'd7:    rcon = 8'h40;
            8'd8:    rcon = 8'h80;
            8'd9:    rcon = 8'h1b;
            8'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        rot_w  = {key[23:0], key[31:24]};
        temp_w = {sub_byte(rot_w[31:24]) ^ rcon, sub_byte(rot_w[23:16]),
                  sub_byte(rot_w[15:8]), sub_byte(rot_w[7:0])};
        w0     = key[127:96] ^ temp_w;
        w1     = key[95:64]  ^ w0;
        w2     = key[63:32]  ^ w1;
        w3     = key[31:0]   ^ w2;
        exkey  = {w0, w1, w2, w3};
    end
endmodule

module aes_key_sched_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         key_valid,
    input  logic [3:0]   rk_rd_addr,
`ifdef KEY_SCHED_STREAM_EN
    output logic [127:0] rk_rd_data,
    output logic         rk_strm_valid,
    output logic [127:0] rk_strm_data
`else
    output logic [127:0] rk_rd_data
`endif
);
    localparam logic [3:0] NR4 = 4'(NR);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic         busy_q, busy_d, done_q, done_d, kv_q, kv_d;
    logic [127:0] rk_q [0:NR];
    logic [127:0] rk_d [0:NR];
    logic [3:0]   prev_idx;
    logic [127:0] exkey;
`ifdef KEY_SCHED_STREAM_EN
    logic         strm_valid_q, strm_valid_d;
    logic [127:0] strm_data_q, strm_data_d;
`endif

    // Outside EXPAND the index and count are don't-care; clamp to keep the read in range.
    assign prev_idx = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;

    aes_expand_key u_expand (
        .key   (rk_q[prev_idx]),
        .count ({4'h0, round_q}),
        .exkey (exkey)
    );

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        kv_d    = kv_q;
        for (int i = 0; i <= NR; i++) rk_d[i] = rk_q[i];
`ifdef KEY_SCHED_STREAM_EN
        strm_valid_d = 1'b0;
        strm_data_d  = strm_data_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    rk_d[0] = key_in;
                    round_d = 4'd1;
                    state_d = EXPAND;
                    busy_d  = 1'b1;
                    kv_d    = 1'b0;
`ifdef KEY_SCHED_STREAM_EN
                    strm_valid_d = 1'b1;
                    strm_data_d  = key_in;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            EXPAND: begin
                rk_d[round_q] = exkey;
`ifdef KEY_SCHED_STREAM_EN
                strm_valid_d = 1'b1;
                strm_data_d  = exkey;
`endif
                // round stays at NR on the final edge so it never exceeds NR
                if (round_q == NR4) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    kv_d    = 1'b1;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            kv_q    <= 1'b0;
            for (int i = 0; i <= NR; i++) rk_q[i] <= 128'h0;
`ifdef KEY_SCHED_STREAM_EN
            strm_valid_q <= 1'b0;
            strm_data_q  <= 128'h0;
`endif
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            kv_q    <= kv_d;
            for (int i = 0; i <= NR; i++) rk_q[i] <= rk_d[i];
`ifdef KEY_SCHED_STREAM_EN
            strm_valid_q <= strm_valid_d;
            strm_data_q  <= strm_data_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign key_valid  = kv_q;
    assign rk_rd_data = (rk_rd_addr <= NR4) ? rk_q[rk_rd_addr] : 128'h0;
`ifdef KEY_SCHED_STREAM_EN
    assign rk_strm_valid = strm_valid_q;
    assign rk_strm_data  = strm_data_q;
`endif
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - scoreboard bench for aes_key_sched_ctrl

module tb_aes_key_sched_ctrl;
    localparam logic [127:0] KEY1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1_1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] K1_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K2_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy, done, key_valid;
    logic [3:0]   rk_rd_addr;
    logic [127:0] rk_rd_data;
`ifdef KEY_SCHED_STREAM_EN
    logic         rk_strm_valid;
    logic [127:0] rk_strm_data;
    logic [127:0] strm_q [$];
`endif

    logic [127:0] exp_q [$];
    int n_cmp = 0, n_bad = 0, done_cnt = 0, busy_cnt = 0;

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .key_valid  (key_valid),
        .rk_rd_addr (rk_rd_addr),
`ifdef KEY_SCHED_STREAM_EN
        .rk_rd_data (rk_rd_data),
        .rk_strm_valid (rk_strm_valid),
        .rk_strm_data  (rk_strm_data)
`else
        .rk_rd_data (rk_rd_data)
`endif
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_cnt++;
`ifdef KEY_SCHED_STREAM_EN
        if (rk_strm_valid) strm_q.push_back(rk_strm_data);
`endif
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_rk(input logic [3:0] a, output logic [127:0] d);
        rk_rd_addr = a;
        #1;
        d = rk_rd_data;
    endtask

    // Drives start for one cycle; returns at the negedge following the accepting edge.
    task automatic kick(input logic [127:0] k, input bit push, input logic [127:0] exp10);
        if (push) exp_q.push_back(exp10);
        @(negedge clk);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic finish_check(input string tag, input int edges_in);
        int edges;
        logic [127:0] exp10, d;
        edges = edges_in;
        while (!done && edges < 60) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, 128'(edges), 128'd11);
        check({tag, "_key_valid"}, {127'h0, key_valid}, 128'h1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 128'h1, 128'h0);
        end else begin
            exp10 = exp_q.pop_front();
            read_rk(4'd10, d);
            check({tag, "_rk10"}, d, exp10);
        end
    endtask

    logic [127:0] d;
    int dc0;

    initial begin
        rst_n = 1'b0; start = 1'b0; key_in = '0; rk_rd_addr = '0;
        #1;
        check("rst_busy", {127'h0, busy}, 128'h0);
        check("rst_done", {127'h0, done}, 128'h0);
        check("rst_kv", {127'h0, key_valid}, 128'h0);
        read_rk(4'd10, d); check("rst_rk10", d, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1
        busy_cnt = 0;
`ifdef KEY_SCHED_STREAM_EN
        strm_q.delete();
`endif
        kick(KEY1, 1'b1, K1_10);
        check("s1_busy", {127'h0, busy}, 128'h1);
        check("s1_kv_low", {127'h0, key_valid}, 128'h0);
        finish_check("s1", 1);
        read_rk(4'd1, d); check("s1_rk1", d, K1_1);
        read_rk(4'd0, d); check("s1_rk0", d, KEY1);
        check("s1_busy_cycles", 128'(busy_cnt), 128'd10);
        @(negedge clk);
        check("s1_done_pulse", {127'h0, done}, 128'h0);
`ifdef KEY_SCHED_STREAM_EN
        check("s6_beats", 128'(strm_q.size()), 128'd11);
        if (strm_q.size() == 11) begin
            check("s6_beat0", strm_q[0], KEY1);
            check("s6_beat1", strm_q[1], K1_1);
            check("s6_beat10", strm_q[10], K1_10);
        end
`endif

        // Scenario 2
        kick(KEY2, 1'b1, K2_10);
        finish_check("s2", 1);
        read_rk(4'd1, d); check("s2_rk1", d, K2_1);
        for (int a = 11; a <= 15; a++) begin
            read_rk(4'(a), d);
            check($sformatf("s2_oob%0d", a), d, 128'h0);
        end

        // Scenario 3: start and key_in disturbed mid-expansion
        dc0 = done_cnt;
        kick(KEY1, 1'b1, K1_10);
        repeat (4) @(negedge clk);
        start = 1'b1; key_in = KEY2;
        @(negedge clk);
        start = 1'b0;
        finish_check("s3", 6);
        repeat (3) @(negedge clk);
        check("s3_one_done", 128'(done_cnt - dc0), 128'd1);

        // Scenario 4: reset after round 4
        kick(KEY1, 1'b0, '0);
        repeat (4) @(negedge clk);
        dc0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("s4_busy", {127'h0, busy}, 128'h0);
        read_rk(4'd0, d); check("s4_rk0", d, 128'h0);
        read_rk(4'd4, d); check("s4_rk4", d, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("s4_no_done", 128'(done_cnt - dc0), 128'd0);
        kick(KEY2, 1'b1, K2_10);
        finish_check("s4", 1);

        // Scenario 5: start held across DONE
        kick(KEY1, 1'b1, K1_10);
        finish_check("s5a", 1);
        exp_q.push_back(K2_10);
        start = 1'b1; key_in = KEY2;
        @(negedge clk);
        start = 1'b0;
        check("s5_busy", {127'h0, busy}, 128'h1);
        check("s5_kv_drop", {127'h0, key_valid}, 128'h0);
        check("s5_done_low", {127'h0, done}, 128'h0);
        finish_check("s5b", 1);

        check("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 Parameter NR, default 10: number of expansion rounds (AES-128); legal value is 10 only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to expand key_in; sampled only in IDLE or DONE.
REQ-005 key_in  input  128  cipher key; sampled on the accepting edge only.
REQ-006 busy  output  1  high while expansion is in progress.
REQ-007 done  output  1  one-cycle pulse when round key NR has been written.
REQ-008 key_valid  output  1  high while all NR+1 round keys in the table belong to the last accepted key.
REQ-009 rk_rd_addr  input  4  round-key table read index, 0..NR.
REQ-010 rk_rd_data  output  128  round key at rk_rd_addr, combinational read.

Function
REQ-011 The block SHALL own a table rk[0..NR] of 128-bit registers and one combinational expandKey instance (key, count, exkey), where key = rk[round-1], count = {4'h0, round}, and exkey is the next round key.
REQ-012 The FSM SHALL have states IDLE, EXPAND and DONE; the reset state is IDLE.
REQ-013 IDLE/DONE with start=1 at edge E0: rk[0] <= key_in, round <= 1, state <= EXPAND, busy <= 1, key_valid <= 0.
REQ-014 EXPAND at edge Ei (i = 1..NR): rk[i] <= exkey, round <= round+1; rk[0] and all other entries are held.
REQ-015 At edge E(NR): state <= DONE, busy <= 0, done <= 1, key_valid <= 1.
REQ-016 DONE SHALL last exactly one cycle: done <= 0; next state is EXPAND if start=1 (back-to-back, per REQ-013), else IDLE.
REQ-017 Latency: done is high in the cycle following edge E(NR), i.e. NR+1 edges after the accepting edge; busy is high for exactly NR cycles.
REQ-018 start while busy=1 SHALL be ignored; key_in changes while busy SHALL NOT affect the result.
REQ-019 rk_rd_data = rk[rk_rd_addr] for addr 0..NR; for addr > NR it SHALL read 128'h0.
REQ-020 While busy, reads of entries not yet written SHALL return their prior contents; key_valid=0 marks them stale.
REQ-021 round SHALL be 4 bits and SHALL never exceed NR; count presented to expandKey outside EXPAND is don't-care.

Reset
REQ-022 With rst_n low, state=IDLE, round=0, busy=0, done=0, key_valid=0, and all rk entries = 128'h0, applied immediately without waiting for clk.
REQ-023 Reset asserted mid-expansion SHALL abort the expansion; no done pulse follows, and the first post-reset start begins a full expansion.

Configuration
REQ-024 Macro KEY_SCHED_STREAM_EN defined: add outputs rk_strm_valid (1) and rk_strm_data (128); in the cycle after each edge E0..E(NR), rk_strm_valid=1 and rk_strm_data = the entry just written (rk[0] first, rk[NR] last; 11 beats, no backpressure); both reset to 0.
REQ-025 KEY_SCHED_STREAM_EN undefined: these ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-026 Scenario 1: key_in=000102030405060708090a0b0c0d0e0f, start one cycle -> done after 11 edges; rk[1]=d6aa74fdd2af72fadaa678f1d6ab76fe; rk[10]=13111d7fe3944a17f307a78b4d2b30c5; key_valid=1.
REQ-027 Scenario 2: key_in=2b7e151628aed2a6abf7158809cf4f3c -> rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6; rk_rd_addr=11..15 -> rk_rd_data=0.
REQ-028 Scenario 3: start pulsed again and key_in changed at round 5 -> ignored; result equals Scenario 1; exactly one done pulse.
REQ-029 Scenario 4: rst_n low after round 4 -> busy=0, all rk=0, no done; restart with Scenario 2 key -> correct rk[10].
REQ-030 Scenario 5: start held high across the DONE cycle -> new expansion begins with no idle cycle; key_valid drops at the accepting edge.
REQ-031 Scenario 6 (KEY_SCHED_STREAM_EN): Scenario 1 stimulus -> 11 consecutive rk_strm_valid beats matching rk[0..10] in order.
